imm_extend_stage: RTL and testbench
===================================

# imm_extend_stage

Parametrised, registered immediate-extension stage for the MIPS pipeline decode path. It replaces the fixed two-mode combinational extender with four selectable extension modes, configurable widths, and a valid/ready handshake. A one-entry skid buffer lets the downstream EX stage stall without creating a combinational ready path back into decode. A flush input supports branch/jump squash.

## Interface
Parameters:
- DATA_W, 32, output operand width; must be ≥ IMM_W
- IMM_W, 16, raw immediate field width
- SHAMT_W, 5, shift-amount field width; must be ≤ IMM_W
- TAG_W, 5, sideband tag carried alongside each result (e.g. destination register index)

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all held and incoming entries
- in_valid  in  1  input entry present
- in_ready  out  1  stage can accept an entry this cycle
- in_imm  in  IMM_W  raw immediate field
- in_mode  in  2  extension mode
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result this cycle
- out_data  out  DATA_W  extended operand
- out_tag  out  TAG_W  tag that travelled with out_data

## Operation
- Modes (in_mode):
  - 00 SEXT: replicate in_imm[IMM_W-1] into the upper DATA_W-IMM_W bits
  - 01 ZEXT: zero upper bits
  - 10 LUI: in_imm placed in the top IMM_W bits, low DATA_W-IMM_W bits zero; if DATA_W == IMM_W, result equals in_imm
  - 11 SHAMT: in_imm[SHAMT_W-1:0] zero-extended; upper in_imm bits ignored
- Extension is computed combinationally from the input and captured into the stage register on accept. Mode is not stored.
- Storage: main output register (drives out_*) plus a one-entry skid register.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- in_ready = skid empty. It is a registered-state function only and has no combinational dependence on out_ready.
- Accept while the main register is empty, or while it is draining this cycle: the entry goes to the main register.
- Accept while the main register is full and not draining: the entry goes to skid, and in_ready drops next cycle.
- Main register drains while skid is full: skid moves to main and skid empties. Order is always preserved.
- flush: both registers are cleared and out_valid is 0 next cycle. Any entry offered in the same cycle is dropped, even if in_ready was 1. flush wins over all other simultaneous events.
- Reset (async assert, sync-safe deassert is the top level's responsibility): out_valid=0, out_data=0, out_tag=0, skid empty, so in_ready=1 while in reset.
- out_data and out_tag hold stable while out_valid && !out_ready.

## Timing
- Latency: 1 cycle from input accept to out_valid, when the main register is empty or draining.
- Throughput: 1 entry per cycle with out_ready held high.
- Stall: the first out_ready=0 cycle absorbs at most one extra entry (skid). in_ready is low from the following cycle until the main register drains.
- Release after stall: skid data appears on out_* in the cycle after the main register transfers, and in_ready returns high in that same cycle.
- Flush: takes effect at the next edge. Nothing is emitted from pre-flush entries after that edge.

## Structure
- Shared package mips_pkg holds the mode encodings (MODE_SEXT, MODE_ZEXT, MODE_LUI, MODE_SHAMT) and the default widths, so decode and the bench share them.
- One sub-module, imm_extend_core: purely combinational, takes imm and mode and produces the DATA_W result. It is instantiated once at the stage input.
- The top level holds the main/skid registers and handshake logic.
- Elaboration-time checks reject DATA_W < IMM_W and SHAMT_W > IMM_W.

## Test plan
- Reset: hold rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_tag=0, in_ready=1 immediately (async).
- Mode sweep, defaults:
  - imm=16'h8001, SEXT -> 32'hFFFF8001
  - same imm, ZEXT -> 32'h00008001
  - same imm, LUI -> 32'h80010000
  - imm=16'hFFFF, SHAMT -> 32'h0000001F
  - each appears 1 cycle after accept with matching tag
- Back-to-back with out_ready=1: 8 entries on consecutive cycles -> 8 results on consecutive cycles, in order, no bubbles.
- Stall: out_ready=0 while entries A, B are sent -> A on out_*, B in skid, in_ready=0. Raise out_ready -> A then B on consecutive cycles, and in_ready=1 the cycle B reaches out_*.
- Flush with simultaneous in_valid while main and skid are full -> out_valid=0 next cycle. The new entry is never emitted, and in_ready=1.
- Parameter variant DATA_W=16, IMM_W=16, SHAMT_W=4: LUI of 16'h1234 -> 16'h1234; SHAMT of 16'h00F7 -> 16'h0007.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared decode-path definitions: immediate extension mode encodings and default widths.
package mips_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_IMM_W   = 16;
    localparam int DEF_SHAMT_W = 5;
    localparam int DEF_TAG_W   = 5;

    typedef enum logic [1:0] {
        MODE_SEXT  = 2'b00,
        MODE_ZEXT  = 2'b01,
        MODE_LUI   = 2'b10,
        MODE_SHAMT = 2'b11
    } imm_mode_e;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: four modes selectable per entry.
module imm_extend_core
    import mips_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int IMM_W   = DEF_IMM_W,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] result
);

    // Size casts handle DATA_W == IMM_W without zero-width replications.
    always_comb begin
        result = '0;
        case (imm_mode_e'(mode))
            MODE_SEXT:  result = DATA_W'($signed(imm));
            MODE_ZEXT:  result = DATA_W'(imm);
            MODE_LUI:   result = DATA_W'(imm) << (DATA_W - IMM_W);
            MODE_SHAMT: result = DATA_W'(imm[SHAMT_W-1:0]);
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage with valid/ready handshake, one-entry
// skid buffer (in_ready depends on registered state only) and synchronous flush.
module imm_extend_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int IMM_W   = DEF_IMM_W,
    parameter int SHAMT_W = DEF_SHAMT_W,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [1:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag
);

    if (DATA_W < IMM_W) begin : g_bad_data_w
        $error("imm_extend_stage: DATA_W must be >= IMM_W");
    end
    if (SHAMT_W > IMM_W) begin : g_bad_shamt_w
        $error("imm_extend_stage: SHAMT_W must be <= IMM_W");
    end

    logic [DATA_W-1:0] ext_data;

    logic              main_valid, main_valid_nx;
    logic [DATA_W-1:0] main_data,  main_data_nx;
    logic [TAG_W-1:0]  main_tag,   main_tag_nx;
    logic              skid_valid, skid_valid_nx;
    logic [DATA_W-1:0] skid_data,  skid_data_nx;
    logic [TAG_W-1:0]  skid_tag,   skid_tag_nx;
    logic              accept;
    logic              drain;

    imm_extend_core #(
        .DATA_W  (DATA_W),
        .IMM_W   (IMM_W),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .imm    (in_imm),
        .mode   (in_mode),
        .result (ext_data)
    );

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_tag   = main_tag;
    assign accept    = in_valid && !skid_valid;
    assign drain     = main_valid && out_ready;

    // Next-state for main/skid: skid always refills main first so order is kept.
    always_comb begin
        main_valid_nx = main_valid;
        main_data_nx  = main_data;
        main_tag_nx   = main_tag;
        skid_valid_nx = skid_valid;
        skid_data_nx  = skid_data;
        skid_tag_nx   = skid_tag;
        if (flush) begin
            main_valid_nx = 1'b0;
            main_data_nx  = '0;
            main_tag_nx   = '0;
            skid_valid_nx = 1'b0;
            skid_data_nx  = '0;
            skid_tag_nx   = '0;
        end else if (!main_valid || drain) begin
            if (skid_valid) begin
                main_valid_nx = 1'b1;
                main_data_nx  = skid_data;
                main_tag_nx   = skid_tag;
                skid_valid_nx = 1'b0;
            end else if (accept) begin
                main_valid_nx = 1'b1;
                main_data_nx  = ext_data;
                main_tag_nx   = in_tag;
            end else begin
                main_valid_nx = 1'b0;
            end
        end else if (accept) begin
            skid_valid_nx = 1'b1;
            skid_data_nx  = ext_data;
            skid_tag_nx   = in_tag;
        end
    end

    // Stage registers with asynchronous reset to an empty pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_tag   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_tag   <= '0;
        end else begin
            main_valid <= main_valid_nx;
            main_data  <= main_data_nx;
            main_tag   <= main_tag_nx;
            skid_valid <= skid_valid_nx;
            skid_data  <= skid_data_nx;
            skid_tag   <= skid_tag_nx;
        end
    end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage: directed vector table, handshake
// corner sequences, randomized run against a queue-based reference model,
// and a DATA_W == IMM_W parameter variant.
module tb_imm_extend_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    logic        v_flush = 1'b0;
    logic        v_in_valid = 1'b0;
    logic        v_in_ready;
    logic [15:0] v_in_imm = '0;
    logic [1:0]  v_in_mode = '0;
    logic [4:0]  v_in_tag = '0;
    logic        v_out_valid;
    logic        v_out_ready = 1'b1;
    logic [15:0] v_out_data;
    logic [4:0]  v_out_tag;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_extend_stage u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    imm_extend_stage #(
        .DATA_W  (16),
        .IMM_W   (16),
        .SHAMT_W (4),
        .TAG_W   (5)
    ) u_var (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (v_flush),
        .in_valid  (v_in_valid),
        .in_ready  (v_in_ready),
        .in_imm    (v_in_imm),
        .in_mode   (v_in_mode),
        .in_tag    (v_in_tag),
        .out_valid (v_out_valid),
        .out_ready (v_out_ready),
        .out_data  (v_out_data),
        .out_tag   (v_out_tag)
    );

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } entry_t;

    // Arithmetic statement of the extension rules for any width set.
    function automatic longint unsigned ref_ext(longint unsigned imm, int mode, int dw, int iw, int sw);
        longint unsigned full;
        longint unsigned r;
        full = 64'd1 << dw;
        case (mode)
            0:       r = (imm >= (64'd1 << (iw - 1))) ? imm + full - (64'd1 << iw) : imm;
            1:       r = imm;
            2:       r = imm * (64'd1 << (dw - iw));
            default: r = imm % (64'd1 << sw);
        endcase
        return r % full;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [15:0] imm, logic [1:0] mode, logic [4:0] tag);
        in_valid = v;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
    endtask

    vec_t   vecs[8];
    entry_t model_q[$];
    entry_t b2b[8];

    initial begin
        vecs[0] = '{16'h8001, 2'b00, 5'd1, 32'hFFFF8001};
        vecs[1] = '{16'h8001, 2'b01, 5'd2, 32'h00008001};
        vecs[2] = '{16'h8001, 2'b10, 5'd3, 32'h80010000};
        vecs[3] = '{16'hFFFF, 2'b11, 5'd4, 32'h0000001F};
        vecs[4] = '{16'h7FFF, 2'b00, 5'd5, 32'h00007FFF};
        vecs[5] = '{16'hFFFF, 2'b01, 5'd6, 32'h0000FFFF};
        vecs[6] = '{16'hFFFF, 2'b10, 5'd7, 32'hFFFF0000};
        vecs[7] = '{16'h0020, 2'b11, 5'd31, 32'h00000000};

        // Reset state
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed mode table, 1-cycle latency each
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].imm, vecs[i].mode, vecs[i].tag);
            tick();
            drive(1'b0, '0, '0, '0);
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
            check($sformatf("vec%0d_tag", i), out_tag, vecs[i].tag);
            tick();
            check($sformatf("vec%0d_empty", i), out_valid, 0);
        end

        // Back-to-back, 8 entries, no bubbles
        for (int i = 0; i < 8; i++) begin
            logic [15:0] imm;
            imm = 16'($urandom);
            b2b[i].data = 32'(ref_ext(64'(imm), i % 4, 32, 16, 5));
            b2b[i].tag  = 5'(i + 8);
            drive(1'b1, imm, 2'(i % 4), b2b[i].tag);
            tick();
            check($sformatf("b2b%0d_valid", i), out_valid, 1);
            check($sformatf("b2b%0d_data", i), out_data, b2b[i].data);
            check($sformatf("b2b%0d_tag", i), out_tag, b2b[i].tag);
        end
        drive(1'b0, '0, '0, '0);
        tick();
        check("b2b_done_empty", out_valid, 0);

        // Stall: A to main, B to skid, then release
        out_ready = 1'b0;
        drive(1'b1, 16'h00AA, 2'b01, 5'd10);
        tick();
        check("stall_a_valid", out_valid, 1);
        check("stall_a_in_ready", in_ready, 1);
        drive(1'b1, 16'hFFFE, 2'b00, 5'd11);
        tick();
        drive(1'b0, '0, '0, '0);
        check("stall_hold_a_data", out_data, 32'h000000AA);
        check("stall_hold_a_tag", out_tag, 10);
        check("stall_in_ready_low", in_ready, 0);
        tick();
        check("stall_still_a", out_data, 32'h000000AA);
        check("stall_still_low", in_ready, 0);
        out_ready = 1'b1;
        tick();
        check("release_b_valid", out_valid, 1);
        check("release_b_data", out_data, 32'hFFFFFFFE);
        check("release_b_tag", out_tag, 11);
        check("release_in_ready", in_ready, 1);
        tick();
        check("release_empty", out_valid, 0);

        // Flush with main and skid full and a new entry offered
        out_ready = 1'b0;
        drive(1'b1, 16'h0001, 2'b01, 5'd1);
        tick();
        drive(1'b1, 16'h0002, 2'b01, 5'd2);
        tick();
        check("flush_pre_in_ready", in_ready, 0);
        flush = 1'b1;
        drive(1'b1, 16'h0003, 2'b01, 5'd3);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("flush_quiet%0d", i), out_valid, 0);
        end

        // Randomized run against a depth-2 queue model
        model_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic        acc;
            logic        pop;
            entry_t      e;
            logic [15:0] imm;
            logic [1:0]  mode;
            imm  = 16'($urandom);
            mode = 2'($urandom_range(0, 3));
            drive(($urandom % 4) != 0, imm, mode, 5'($urandom));
            out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 32) == 0;
            check("rnd_in_ready", in_ready, (model_q.size() < 2) ? 1 : 0);
            acc = in_valid && (model_q.size() < 2);
            pop = out_ready && (model_q.size() > 0);
            e.data = 32'(ref_ext(64'(imm), int'(mode), 32, 16, 5));
            e.tag  = in_tag;
            if (flush) begin
                model_q.delete();
            end else begin
                if (pop) void'(model_q.pop_front());
                if (acc) model_q.push_back(e);
            end
            tick();
            check("rnd_out_valid", out_valid, (model_q.size() > 0) ? 1 : 0);
            if (model_q.size() > 0) begin
                check("rnd_out_data", out_data, model_q[0].data);
                check("rnd_out_tag", out_tag, model_q[0].tag);
            end
        end
        flush = 1'b1;
        drive(1'b0, '0, '0, '0);
        tick();
        flush = 1'b0;

        // Asynchronous reset mid-stream while holding a result
        out_ready = 1'b0;
        drive(1'b1, 16'h1357, 2'b10, 5'd21);
        tick();
        drive(1'b1, 16'h2468, 2'b10, 5'd22);
        check("mid_pre_valid", out_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_tag", out_tag, 0);
        check("mid_rst_in_ready", in_ready, 1);
        drive(1'b0, '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // DATA_W == IMM_W variant
        v_in_valid = 1'b1; v_in_imm = 16'h1234; v_in_mode = 2'b10; v_in_tag = 5'd9;
        tick();
        check("var_lui_data", v_out_data, 16'h1234);
        check("var_lui_tag", v_out_tag, 9);
        v_in_imm = 16'h00F7; v_in_mode = 2'b11; v_in_tag = 5'd10;
        tick();
        check("var_shamt_data", v_out_data, 16'h0007);
        v_in_imm = 16'h8001; v_in_mode = 2'b00; v_in_tag = 5'd11;
        tick();
        check("var_sext_data", v_out_data, 16'h8001);
        v_in_valid = 1'b0;
        tick();
        check("var_empty", v_out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
